// File: rtl/wb_arbiter_pkg.sv
// Shared defaults and the round-robin tie-break helper for the Wishbone arbiter.
package wb_arbiter_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int DEFAULT_TIMEOUT_WIDTH  = 8;

    // Master 1 wins when it is the only requester, or on a tie when master 0 won last.
    function automatic logic pick_m1(input logic req0, input logic req1, input logic last_grant);
        return req1 && (!req0 || !last_grant);
    endfunction

endpackage

// File: rtl/wb_arbiter_params.vh
// Owner encodings shared by the arbiter datapath and its arbitration logic.
// Included inside the module body so the constants stay module-local.
`ifndef WB_ARBITER_PARAMS_VH
`define WB_ARBITER_PARAMS_VH
localparam logic [1:0] OWN_NONE = 2'd0;
localparam logic [1:0] OWN_M0   = 2'd1;
localparam logic [1:0] OWN_M1   = 2'd2;
`endif

// File: rtl/wb_timeout.sv
// Stall watchdog: counts strobe cycles without a termination and flags expiry
// on the last allowed cycle. TIMEOUT_CYCLES of 0 keeps expire permanently low.
module wb_timeout
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic pending,
    output logic expire
);

    localparam logic                     ENABLED = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST    = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] ONE     = TIMEOUT_WIDTH'(1);

    logic [TIMEOUT_WIDTH-1:0] count_q, count_d;

    assign expire = ENABLED && pending && (count_q == LAST);

    always_comb begin
        count_d = count_q + ONE;
        if (!ENABLED || clear || !pending || expire) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone B4 classic arbiter with registered round-robin
// ownership and a stall watchdog that terminates hung cycles with err.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TIMEOUT_WIDTH  = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i
);

`include "wb_arbiter_params.vh"

    logic [1:0] owner_q, owner_d;
    logic       last_grant_q, last_grant_d;
    logic       own_m0, own_m1;
    logic       stb_raw;
    logic       slave_term;
    logic       stb_pending;
    logic       expire;
    logic       owner_change;

    assign own_m0 = (owner_q == OWN_M0);
    assign own_m1 = (owner_q == OWN_M1);

    always_comb begin
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        case (owner_q)
            OWN_M0: begin
                s_cyc_o = m0_cyc_i;
                stb_raw = m0_stb_i;
                s_we_o  = m0_we_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
                s_sel_o = m0_sel_i;
            end
            OWN_M1: begin
                s_cyc_o = m1_cyc_i;
                stb_raw = m1_stb_i;
                s_we_o  = m1_we_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
                s_sel_o = m1_sel_i;
            end
            default: ;
        endcase
    end

    // The watchdog swallows the strobe in its expiry cycle so the slave never
    // sees a beat that has already been answered with a synthetic err.
    assign slave_term  = s_ack_i | s_err_i | s_rty_i;
    assign stb_pending = stb_raw & ~slave_term;
    assign s_stb_o     = stb_raw & ~expire;

    // Arbitration is open whenever the bus has no owner holding cyc, which
    // covers both the idle state and the owner's release cycle.
    always_comb begin
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if (!s_cyc_o) begin
            if (m0_cyc_i || m1_cyc_i) begin
                if (pick_m1(m0_cyc_i, m1_cyc_i, last_grant_q)) begin
                    owner_d      = OWN_M1;
                    last_grant_d = 1'b1;
                end else begin
                    owner_d      = OWN_M0;
                    last_grant_d = 1'b0;
                end
            end else begin
                owner_d = OWN_NONE;
            end
        end
    end

    assign owner_change = (owner_d != owner_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q      <= OWN_NONE;
            last_grant_q <= 1'b1;
        end else begin
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (owner_change),
        .pending (stb_pending),
        .expire  (expire)
    );

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    assign m0_ack_o = own_m0 & s_ack_i;
    assign m0_err_o = own_m0 & (s_err_i | expire);
    assign m0_rty_o = own_m0 & s_rty_i;
    assign m1_ack_o = own_m1 & s_ack_i;
    assign m1_err_o = own_m1 & (s_err_i | expire);
    assign m1_rty_o = own_m1 & s_rty_i;

endmodule
